// File: rtl/bcd_digit_formatter_if.sv
// rtl/bcd_digit_formatter_if.sv - request handshake bundle for bcd_digit_formatter
//   value_i : unsigned binary value to convert (WIDTH bits)
//   valid_i : request; value_i is sampled when valid_i && ready_o
//   ready_o : converter idle and able to accept a value
interface bcd_digit_formatter_if #(
    parameter int WIDTH = 14
);
    logic [WIDTH-1:0] value_i;
    logic             valid_i;
    logic             ready_o;

    modport master (
        output value_i,
        output valid_i,
        input  ready_o
    );

    modport slave (
        input  value_i,
        input  valid_i,
        output ready_o
    );
endinterface

// File: rtl/bcd_digit_formatter.sv
// rtl/bcd_digit_formatter.sv - sequential double-dabble binary to 4-digit BCD with blanking and 9999 clamp
//   clk_i, rst_i         : clock, synchronous active-high reset
//   req (slave)          : value_i / valid_i / ready_o request handshake
//   done_o               : one-cycle pulse when new digits first appear
//   overflow_o           : last accepted value exceeded 9999
//   digitN_i_o           : BCD digits (digit0 = ones), held between conversions
//   digitN_en_o          : digit enables for the 7-segment driver
module bcd_digit_formatter #(
    parameter int WIDTH    = 14,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    bcd_digit_formatter_if.slave req,
    output logic                 done_o,
    output logic                 overflow_o,
    output logic [3:0]           digit0_i_o,
    output logic [3:0]           digit1_i_o,
    output logic [3:0]           digit2_i_o,
    output logic [3:0]           digit3_i_o,
    output logic                 digit0_en_o,
    output logic                 digit1_en_o,
    output logic                 digit2_en_o,
    output logic                 digit3_en_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam logic [4:0] CNT_INIT  = 5'(WIDTH);
    localparam logic [3:0] EN_RESET  = BLANK_LZ ? 4'b0001 : 4'b1111;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [15:0]      scratch_q, scratch_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      digits_q, digits_d;
    logic [3:0]       en_q, en_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;

    logic             over;
    logic [WIDTH-1:0] clamped;
    logic [14:0]      adj;
    logic [3:0]       lz_en;

    // Values above 9999 can only exist when WIDTH >= 14; narrower inputs
    // get a constant-false clamp.
    if (WIDTH >= 14) begin : g_clamp
        localparam logic [WIDTH-1:0] MAXV = WIDTH'(9999);
        assign over    = (req.value_i > MAXV);
        assign clamped = over ? MAXV : req.value_i;
    end else begin : g_noclamp
        assign over    = 1'b0;
        assign clamped = req.value_i;
    end

    assign req.ready_o = (state_q == IDLE);

    // Add-3 correction. The top nibble never exceeds 9 (input is clamped),
    // so its corrected value always fits in 3 bits before the shift drops
    // the top bit anyway.
    always_comb begin
        adj = '0;
        for (int i = 0; i < 3; i++) begin
            adj[i*4 +: 4] = (scratch_q[i*4 +: 4] >= 4'd5) ? scratch_q[i*4 +: 4] + 4'd3
                                                           : scratch_q[i*4 +: 4];
        end
        adj[14:12] = scratch_q[14:12] + ((scratch_q[15:12] >= 4'd5) ? 3'd3 : 3'd0);
    end

    always_comb begin
        lz_en = 4'b1111;
        if (BLANK_LZ) begin
            lz_en[3] = (scratch_q[15:12] != 4'd0);
            lz_en[2] = (scratch_q[15:8]  != 8'd0);
            lz_en[1] = (scratch_q[15:4]  != 12'd0);
            lz_en[0] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        digits_d   = digits_q;
        en_d       = en_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (req.valid_i) begin
                    bin_d     = clamped;
                    scratch_d = '0;
                    cnt_d     = CNT_INIT;
                    ovf_d     = over;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = {adj, bin_q[WIDTH-1]};
                bin_d     = bin_q << 1;
                cnt_d     = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                digits_d   = scratch_q;
                en_d       = lz_en;
                overflow_d = ovf_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            digits_q   <= '0;
            en_q       <= EN_RESET;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            digits_q   <= digits_d;
            en_q       <= en_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign done_o      = done_q;
    assign overflow_o  = overflow_q;
    assign digit0_i_o  = digits_q[3:0];
    assign digit1_i_o  = digits_q[7:4];
    assign digit2_i_o  = digits_q[11:8];
    assign digit3_i_o  = digits_q[15:12];
    assign digit0_en_o = en_q[0];
    assign digit1_en_o = en_q[1];
    assign digit2_en_o = en_q[2];
    assign digit3_en_o = en_q[3];

endmodule

// File: tb/tb_bcd_digit_formatter.sv
// tb/tb_bcd_digit_formatter.sv - scoreboard bench for bcd_digit_formatter (blanking and non-blanking instances)
module tb_bcd_digit_formatter;

    localparam int W = 14;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_digit_formatter_if #(.WIDTH(W)) bus ();
    bcd_digit_formatter_if #(.WIDTH(W)) bus_b ();

    assign bus_b.value_i = bus.value_i;
    assign bus_b.valid_i = bus.valid_i;

    logic        done_a, ovf_a, done_b, ovf_b;
    logic [15:0] a_dig, b_dig;
    logic [3:0]  a_en, b_en;

    bcd_digit_formatter #(.WIDTH(W), .BLANK_LZ(1'b1)) u_dut_a (
        .clk_i       (clk),
        .rst_i       (rst),
        .req         (bus),
        .done_o      (done_a),
        .overflow_o  (ovf_a),
        .digit0_i_o  (a_dig[3:0]),
        .digit1_i_o  (a_dig[7:4]),
        .digit2_i_o  (a_dig[11:8]),
        .digit3_i_o  (a_dig[15:12]),
        .digit0_en_o (a_en[0]),
        .digit1_en_o (a_en[1]),
        .digit2_en_o (a_en[2]),
        .digit3_en_o (a_en[3])
    );

    bcd_digit_formatter #(.WIDTH(W), .BLANK_LZ(1'b0)) u_dut_b (
        .clk_i       (clk),
        .rst_i       (rst),
        .req         (bus_b),
        .done_o      (done_b),
        .overflow_o  (ovf_b),
        .digit0_i_o  (b_dig[3:0]),
        .digit1_i_o  (b_dig[7:4]),
        .digit2_i_o  (b_dig[11:8]),
        .digit3_i_o  (b_dig[15:12]),
        .digit0_en_o (b_en[0]),
        .digit1_en_o (b_en[1]),
        .digit2_en_o (b_en[2]),
        .digit3_en_o (b_en[3])
    );

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  en;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t q[$];
    exp_t e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference: decimal digits of the clamped value by plain arithmetic.
    function automatic exp_t model(input int v, input int acc);
        exp_t r;
        int   n;
        n      = (v > 9999) ? 9999 : v;
        r.dig  = {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
        r.en   = {n >= 1000, n >= 100, n >= 10, 1'b1};
        r.ovf  = (v > 9999);
        r.acc  = acc;
        return r;
    endfunction

    // Monitor: pops and checks on every done pulse; between pulses the
    // visible outputs must not move.
    logic [20:0] prev_a;
    logic        prev_rst = 1'b1;

    always @(negedge clk) begin
        if (!rst) begin
            if (done_a) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done_o=1 expected no pending conversion at cycle %0d", cyc);
                end else begin
                    e = q.pop_front();
                    check("digits",   32'(a_dig), 32'(e.dig));
                    check("enables",  32'(a_en),  32'(e.en));
                    check("overflow", 32'(ovf_a), 32'(e.ovf));
                    check("latency",  32'(cyc - e.acc), 32'd15);
                    check("b_done",   32'(done_b), 32'd1);
                    check("b_digits", 32'(b_dig), 32'(e.dig));
                    check("b_enables", 32'(b_en), 32'hF);
                    check("b_overflow", 32'(ovf_b), 32'(e.ovf));
                end
            end else if (!prev_rst) begin
                check("stable_outputs", 32'({a_dig, a_en, ovf_a}), 32'(prev_a));
            end
        end
        prev_a   = {a_dig, a_en, ovf_a};
        prev_rst = rst;
    end

    task automatic send(input int v, output int acc);
        @(negedge clk);
        bus.value_i = W'(v);
        bus.valid_i = 1'b1;
        acc = -1;
        for (int t = 0; t < 100; t++) begin
            if (bus.ready_o) begin
                @(posedge clk);
                #1;
                acc = cyc;
                q.push_back(model(v, cyc));
                break;
            end
            @(negedge clk);
        end
        bus.valid_i = 1'b0;
        bus.value_i = W'($urandom);
        if (acc < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got ready_o=0 for 100 cycles expected acceptance of %0d", v);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        @(negedge clk);
    endtask

    task automatic check_reset_state();
        check("rst_ready",   32'(bus.ready_o), 32'd1);
        check("rst_done",    32'(done_a), 32'd0);
        check("rst_ovf",     32'(ovf_a), 32'd0);
        check("rst_digits",  32'(a_dig), 32'd0);
        check("rst_en",      32'(a_en), 32'b0001);
        check("rst_b_en",    32'(b_en), 32'hF);
        check("rst_b_digits", 32'(b_dig), 32'd0);
    endtask

    int acc, prev_acc, v;
    int corner[8] = '{9999, 10000, 9, 10, 99, 100, 999, 1000};

    initial begin
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        bus.value_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state();

        // 1234 with ready_o observed low for the whole conversion
        send(1234, acc);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("ready_busy", 32'(bus.ready_o), 32'd0);
        end
        @(negedge clk);
        check("ready_after", 32'(bus.ready_o), 32'd1);
        drain();

        // directed values: blanking, zero, clamp, exact 9999
        send(7, acc);     drain();
        send(0, acc);     drain();
        send(905, acc);   drain();
        send(12000, acc); drain();
        send(16383, acc); drain();
        send(9999, acc);  drain();

        // requests while busy are dropped
        send(4321, acc);
        repeat (2) @(negedge clk);
        bus.value_i = W'(1111);
        bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (6) @(negedge clk);
        bus.value_i = W'(1111);
        bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        drain();
        repeat (20) @(negedge clk);

        // reset mid-conversion discards the result
        send(8888, acc);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        @(negedge clk);
        check_reset_state();
        repeat (20) @(negedge clk);
        send(42, acc);
        drain();

        // back-to-back throughput: one conversion every WIDTH + 2 cycles
        send($urandom_range(0, 16383), prev_acc);
        for (int i = 0; i < 5; i++) begin
            send($urandom_range(0, 16383), acc);
            check("b2b_period", 32'(acc - prev_acc), 32'd16);
            prev_acc = acc;
        end
        drain();

        // randomized values with random idle gaps
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       v = $urandom_range(0, 16383);
                1:       v = $urandom_range(0, 9999);
                default: v = corner[$urandom_range(0, 7)];
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(v, acc);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected $finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bcd_digit_formatter.md
Name: bcd_digit_formatter

Overview:
- Sequential binary-to-BCD converter that sits directly upstream of the Basys3 four-digit 7-segment driver.
- Converts an unsigned binary value into four BCD digits using shift-and-add-3 (double dabble), one bit per cycle.
- Drives the driver's digitN_i / digitN_en_i inputs, with optional leading-zero blanking.
- Saturates the display to 9999 when the input exceeds the 4-digit range.

Parameters:
- WIDTH, 14, bit width of the binary input; legal range 4..16.
- BLANK_LZ, 1, 1 = blank leading zeros (digit0 always shown); 0 = all four digits always enabled.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous active-high reset
- value_i  input  WIDTH  unsigned binary value to convert
- valid_i  input  1  request; value_i is sampled when valid_i && ready_o
- ready_o  output  1  high only in IDLE
- done_o  output  1  one-cycle pulse in the cycle new digits first appear
- overflow_o  output  1  registered; 1 if the last accepted value was > 9999
- digit0_i_o..digit3_i_o  output  4 each  BCD digits (digit0 = ones), held between conversions
- digit0_en_o..digit3_en_o  output  1 each  digit enables for the driver

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - FSM in IDLE; ready_o = 1; done_o = 0; overflow_o = 0.
  - All digits = 0; digit0_en_o = 1.
  - digit1..3_en_o = 0 if BLANK_LZ = 1, else 1.
- FSM states: IDLE, SHIFT, LOAD.
- IDLE:
  - On the edge where valid_i && ready_o, capture value_i into the shift register and clear the 16-bit BCD scratch register.
  - Load bit counter = WIDTH; go to SHIFT.
  - If value_i > 9999, capture 9999 instead and set an internal ovf flag; otherwise clear ovf.
- SHIFT: each cycle,
  - add 3 to every scratch nibble >= 5;
  - then shift {scratch, binary} left by one;
  - decrement the counter.
  - When the counter reaches 1 (the last shift is performed this cycle), go to LOAD.
- LOAD: on this edge,
  - register scratch into digit outputs and enables; register ovf into overflow_o;
  - done_o = 1 for exactly the following cycle;
  - return to IDLE.
- Latency: acceptance edge E0 → outputs valid and done_o high after edge E0 + WIDTH + 1. With WIDTH = 14 that is 15 cycles; ready_o is low for those 15 cycles.
- Output stability: outputs change only at the LOAD edge or at reset. No intermediate digits are ever visible.
- Handshake:
  - valid_i while busy is ignored and not queued.
  - value_i is only sampled at acceptance; changes afterwards have no effect.
- Enables with BLANK_LZ = 1:
  - digit3_en_o = (d3 != 0)
  - digit2_en_o = (d3 != 0) || (d2 != 0)
  - digit1_en_o = (d3 | d2 | d1) != 0
  - digit0_en_o = 1
  - Value 0 shows a single "0".
- Enables with BLANK_LZ = 0: all enables = 1.
- Width rules:
  - Comparison against 9999 is done at WIDTH bits.
  - If WIDTH < 14, the clamp logic is constant-false and must synthesize away.
  - The scratch register is always 16 bits and never overflows because the input is clamped.
- Simultaneous events: rst_i has priority over valid_i and over the LOAD update.
- Reset mid-operation (SHIFT or LOAD):
  - return to IDLE with reset output values;
  - no done_o pulse; the partial result is discarded.
- Back-to-back: valid_i held high accepts a new value in the cycle after done_o's LOAD edge (ready_o high again in IDLE), giving one conversion per WIDTH + 2 cycles.

Test Plan:
- value_i = 1234, valid_i for 1 cycle → after 15 edges: digits 4,3,2,1; enables 1,1,1,1; overflow_o = 0; done_o high exactly 1 cycle; ready_o low 15 cycles.
- value_i = 7 (BLANK_LZ = 1) → digit0 = 7, digits1..3 = 0, enables digit0 only; repeat with BLANK_LZ = 0 → enables 1,1,1,1 (shows 0007).
- value_i = 0 then value_i = 905 → first: digit0 = 0, enable digit0 only; second: digits 5,0,9,0; enables digit0..2 = 1, digit3 = 0.
- value_i = 12000 and 16383 → digits 9,9,9,9, all enabled, overflow_o = 1; next value_i = 9999 → same digits, overflow_o = 0.
- Accept 4321, pulse valid_i with 1111 at cycles 3 and 10 of the conversion → result 1,2,3,4 only, a single done_o; the 1111 is never converted.
- Accept 8888, assert rst_i at cycle 6 → ready_o = 1 the next cycle, digits 0, digit0_en only, no done_o; then accept 42 → digits 2,4, done_o after 15 edges.
